mmio_bus_responder: RTL and testbench

- Responder side of the processor's memory bus. Decodes the address, write data and write strobe driven by the control unit and datapath, and returns read data on din.
- Read latency is one clock, which matches the processor's fetch wait cycle (T1).
- Hosts internal word RAM, an LED output register, a synchronized switch input port and a free-running prescaled timer.
- Sits at top level between the processor and the board I/O pins.

---
 rtl/mmio_pkg.sv | 33 +++
 rtl/mmio_sync_ram.sv | 24 ++
 rtl/mmio_bus_responder.sv | 116 +++++++++++
 tb/tb_mmio_bus_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus responder: data width, region codes,
// bus request payload and the address-region decoder.
package mmio_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REGION_W = 4;

  typedef enum logic [REGION_W-1:0] {
    REG_RAM   = 4'h0,
    REG_LEDR  = 4'h1,
    REG_TIMER = 4'h2,
    REG_SW    = 4'h3,
    REG_NONE  = 4'hF
  } region_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } bus_req_t;

  // Top address nibble to region; 0x4..0xF collapse to the unmapped code.
  function automatic region_e decode_region(input logic [REGION_W-1:0] code);
    case (code)
      4'h0:    return REG_RAM;
      4'h1:    return REG_LEDR;
      4'h2:    return REG_TIMER;
      4'h3:    return REG_SW;
      default: return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_sync_ram.sv
// Single-port word RAM, registered read, read-before-write on collisions.
// No reset so it maps onto block RAM.
module mmio_sync_ram
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mmio_bus_responder.sv
// Memory-bus responder: RAM, LED register, synchronized switches and a
// prescaled timer, all returning read data one clock after the address.
module mmio_bus_responder
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_AW   = 8,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned LED_W    = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] dout,
  input  logic              w,
  output logic [DATA_W-1:0] din,
  input  logic [LED_W-1:0]  sw,
  output logic [LED_W-1:0]  ledr
);

  localparam int unsigned PRESC_W = 16;

  bus_req_t          req_c;
  region_e           region_c;
  region_e           region_q;
  logic              ram_we_c;
  logic              led_we_c;
  logic              tmr_we_c;
  logic [DATA_W-1:0] rd_c;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] timer_q;
  logic [PRESC_W-1:0] presc_q;
  logic [LED_W-1:0]  sw_meta_q;
  logic [LED_W-1:0]  sw_sync_q;

  assign req_c    = '{addr: addr, wdata: dout, we: w};
  assign region_c = decode_region(req_c.addr[DATA_W-1:DATA_W-REGION_W]);
  assign ram_we_c = req_c.we && (region_c == REG_RAM);
  assign led_we_c = req_c.we && (region_c == REG_LEDR);
  assign tmr_we_c = req_c.we && (region_c == REG_TIMER);

  // Address bits between the RAM index and the region nibble only alias.
  if (RAM_AW < 12) begin : g_alias
    logic unused_alias_c;
    assign unused_alias_c = ^req_c.addr[11:RAM_AW];
  end

  mmio_sync_ram #(
    .RAM_AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (req_c.addr[RAM_AW-1:0]),
    .wdata (req_c.wdata),
    .rdata (ram_rdata)
  );

  // Read value for the non-RAM regions.
  always_comb begin
    rd_c = '0;
    case (region_c)
      REG_LEDR:  rd_c = DATA_W'(ledr);
      REG_TIMER: rd_c = timer_q;
      REG_SW:    rd_c = DATA_W'(sw_sync_q);
      default:   rd_c = '0;
    endcase
  end

  // Region select is delayed one cycle to line up with the RAM's own read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      region_q <= REG_NONE;
      rd_q     <= '0;
    end else begin
      region_q <= region_c;
      rd_q     <= rd_c;
    end
  end

  assign din = (region_q == REG_RAM) ? ram_rdata : rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ledr <= '0;
    end else if (led_we_c) begin
      ledr <= req_c.wdata[LED_W-1:0];
    end
  end

  // A timer store overrides any tick landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      presc_q <= '0;
    end else if (tmr_we_c) begin
      timer_q <= req_c.wdata;
      presc_q <= '0;
    end else if (presc_q == PRESC_W'(PRESCALE - 1)) begin
      timer_q <= timer_q + DATA_W'(1);
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

endmodule

// File: tb/tb_mmio_bus_responder.sv
// Randomized self-checking bench for mmio_bus_responder against a
// transaction-level model of the memory map.
module tb_mmio_bus_responder;

  localparam int unsigned P  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   addr;
  logic [15:0]   dout;
  logic          w;
  logic [15:0]   din;
  logic [LW-1:0] sw;
  logic [LW-1:0] ledr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]   m_ram [2**AW];
  logic [LW-1:0] m_led;
  logic [15:0]   m_tbase;
  int            m_n;
  logic [LW-1:0] m_sw_last;
  logic [LW-1:0] m_sw_prev;

  always #5 clk = ~clk;

  mmio_bus_responder #(
    .RAM_AW   (AW),
    .PRESCALE (P),
    .LED_W    (LW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .dout    (dout),
    .w       (w),
    .din     (din),
    .sw      (sw),
    .ledr    (ledr)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_timer();
    return m_tbase + 16'(m_n / P);
  endfunction

  // Value the bus reads back for an address, given the model's pre-edge state.
  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [AW-1:0] idx;
    idx = a[AW-1:0];
    case (a[15:12])
      4'h0:    return m_ram[idx];
      4'h1:    return 16'(m_led);
      4'h2:    return m_timer();
      4'h3:    return 16'(m_sw_prev);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_led     = '0;
    m_tbase   = '0;
    m_n       = 0;
    m_sw_last = '0;
    m_sw_prev = '0;
  endtask

  // One bus cycle: drive, clock, update model, check din and ledr.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic wr,
                      input bit chk = 1'b1);
    logic [15:0]   exp;
    logic [AW-1:0] idx;
    addr = a;
    dout = d;
    w    = wr;
    exp  = m_read(a);
    idx  = a[AW-1:0];
    @(posedge clk);
    if (wr && a[15:12] == 4'h2) begin
      m_tbase = d;
      m_n     = 0;
    end else begin
      m_n++;
    end
    if (wr && a[15:12] == 4'h0) m_ram[idx] = d;
    if (wr && a[15:12] == 4'h1) m_led = d[LW-1:0];
    m_sw_prev = m_sw_last;
    m_sw_last = sw;
    #1;
    if (chk) check("din", din, exp);
    check("ledr", 16'(ledr), 16'(m_led));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    addr    = 16'h1000;
    dout    = '0;
    w       = 1'b0;
    sw      = '0;
    model_reset();
    #12;
    check("rst_din", din, 16'h0000);
    check("rst_ledr", 16'(ledr), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1;
    check("rel_din", din, 16'h0000);
    step(16'h1000, 16'h0, 1'b0);
    check("first_edge_din", din, 16'h0000);

    // Fill RAM so every later read has a known expectation.
    for (int i = 0; i < 2**AW; i++) step(16'(i), 16'($urandom), 1'b1, 1'b0);

    step(16'h0005, 16'hBEEF, 1'b1);
    step(16'h0005, 16'h0000, 1'b0);
    check("ram_rd", din, 16'hBEEF);
    step(16'h0105, 16'h0000, 1'b0);
    check("ram_alias", din, 16'hBEEF);

    step(16'h0003, 16'h1111, 1'b1);
    step(16'h0003, 16'h2222, 1'b1);
    check("coll_old", din, 16'h1111);
    step(16'h0003, 16'h0000, 1'b0);
    check("coll_new", din, 16'h2222);

    step(16'h1000, 16'hFFFF, 1'b1);
    check("led_out", 16'(ledr), 16'h03FF);
    step(16'h1000, 16'h0000, 1'b0);
    check("led_rd", din, 16'h03FF);
    step(16'h5000, 16'h1234, 1'b1);
    step(16'h5000, 16'h0000, 1'b0);
    check("unmapped_rd", din, 16'h0000);
    check("unmapped_led", 16'(ledr), 16'h03FF);

    step(16'h2000, 16'hFFFE, 1'b1);
    step(16'h2000, 16'h0000, 1'b0);
    check("tmr_load", din, 16'hFFFE);
    for (int i = 0; i < 4; i++) step(16'h2000, 16'h0000, 1'b0);
    check("tmr_inc", din, 16'hFFFF);
    for (int i = 0; i < 4; i++) step(16'h2000, 16'h0000, 1'b0);
    check("tmr_wrap", din, 16'h0000);
    while ((m_n % P) != P - 1) step(16'h2000, 16'h0000, 1'b0);
    step(16'h2000, 16'h0010, 1'b1);
    step(16'h2000, 16'h0000, 1'b0);
    check("tmr_coll", din, 16'h0010);

    sw = '0;
    for (int i = 0; i < 3; i++) step(16'h3000, 16'h0000, 1'b0);
    sw = 10'h155;
    step(16'h3000, 16'h0000, 1'b0);
    check("sw_e1", din, 16'h0000);
    step(16'h3000, 16'h0000, 1'b0);
    check("sw_e2", din, 16'h0000);
    step(16'h3000, 16'h0000, 1'b0);
    check("sw_e3", din, 16'h0155);

    // Reset lands mid-store: the LED write is lost, RAM keeps earlier data.
    addr = 16'h1000;
    dout = 16'h00AA;
    w    = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ledr", 16'(ledr), 16'h0000);
    check("mid_rst_din", din, 16'h0000);
    w = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(16'h1000, 16'h0000, 1'b0);
    step(16'h0005, 16'h0000, 1'b0);
    step(16'h0005, 16'h0000, 1'b0);
    check("ram_persist", din, 16'hBEEF);

    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  rg;
      logic [15:0] a;
      rg = 4'($urandom_range(0, 5));
      a  = {rg, 12'($urandom)};
      if ($urandom_range(0, 7) == 0) sw = LW'($urandom);
      step(a, 16'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
